// File: rtl/pe_mac_acc_if.sv
// ---------------------------------------------------------------------------
// pe_mac_acc_if
// Beat/result bus of the multiply-accumulate processing element.
//   master : drives beats (clear, in_valid, in_data, weight, bias, step,
//            shift, relu_en) and observes busy, out_valid, out_data.
//   slave  : the processing element itself.
// Packing of in_data/weight: element i sits at
//   [DATA_W*N_CELL-1-DATA_W*i -: DATA_W], i.e. element 0 in the MSBs.
// ---------------------------------------------------------------------------
interface pe_mac_acc_if #(
  parameter int DATA_W  = 8,
  parameter int N_CELL  = 9,
  parameter int BIAS_W  = 16,
  parameter int OUT_W   = 8,
  parameter int STEP_W  = 3,
  parameter int SHIFT_W = 3
);
  logic                       clear;
  logic                       in_valid;
  logic [DATA_W*N_CELL-1:0]   in_data;
  logic [DATA_W*N_CELL-1:0]   weight;
  logic [BIAS_W-1:0]          bias;
  logic [STEP_W-1:0]          step;
  logic [SHIFT_W-1:0]         shift;
  logic                       relu_en;
  logic                       busy;
  logic                       out_valid;
  logic [OUT_W-1:0]           out_data;

  modport master (
    output clear, in_valid, in_data, weight, bias, step, shift, relu_en,
    input  busy, out_valid, out_data
  );

  modport slave (
    input  clear, in_valid, in_data, weight, bias, step, shift, relu_en,
    output busy, out_valid, out_data
  );
endinterface

// File: rtl/pe_mac_acc.sv
// ---------------------------------------------------------------------------
// pe_mac_acc
// Multiply-accumulate processing element for the CNN accelerator datapath.
// Each accepted beat multiplies N_CELL signed input/weight pairs (stage 1),
// then reduces them and accumulates over step+1 beats with a single bias add
// per group (stage 2). The group result is arithmetically shifted, optionally
// ReLU'd, saturated to OUT_W and emitted as a one-cycle out_valid pulse.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : pe_mac_acc_if slave (beat inputs, busy/out_valid/out_data)
// ---------------------------------------------------------------------------
module pe_mac_acc #(
  parameter int DATA_W  = 8,
  parameter int N_CELL  = 9,
  parameter int BIAS_W  = 16,
  parameter int ACC_W   = 28,
  parameter int OUT_W   = 8,
  parameter int STEP_W  = 3,
  parameter int SHIFT_W = 3
) (
  input  logic         clk,
  input  logic         reset,
  pe_mac_acc_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Full-precision signed product of two DATA_W elements.
  function automatic logic signed [PROD_W-1:0] mul_f(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    return a_ext * b_ext;
  endfunction

  // Clamp an accumulator-width value into the signed OUT_W range.
  function automatic logic [OUT_W-1:0] sat_f(input logic signed [ACC_W-1:0] v);
    logic [OUT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[OUT_W-1:0];
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

  // Group control state
  logic [STEP_W-1:0]        cnt_r;
  logic [STEP_W-1:0]        step_lat_r;
  logic                     busy_r;

  // Stage 1 registers
  logic                     s1_valid_r;
  logic                     s1_first_r;
  logic                     s1_last_r;
  logic signed [PROD_W-1:0] s1_prod_r [N_CELL];
  logic [BIAS_W-1:0]        s1_bias_r;
  logic [SHIFT_W-1:0]       s1_shift_r;
  logic                     s1_relu_r;

  // Stage 2 registers
  logic signed [ACC_W-1:0]  acc_r;
  logic                     out_valid_r;
  logic [OUT_W-1:0]         out_data_r;

  // Combinational signals
  logic                     first_s;
  logic                     last_s;
  logic                     accept_s;
  logic [STEP_W-1:0]        step_eff_s;
  logic [STEP_W-1:0]        cnt_nxt_s;
  logic signed [PROD_W-1:0] prod_s [N_CELL];
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  base_s;
  logic signed [ACC_W-1:0]  total_s;
  logic signed [ACC_W-1:0]  shifted_s;
  logic signed [ACC_W-1:0]  relu_s;
  logic [OUT_W-1:0]         result_s;

  // Beat counter next-state: the first beat of a group compares against the
  // live step input, later beats against the value latched on the first beat.
  always_comb begin
    first_s    = (cnt_r == STEP_ZERO);
    step_eff_s = first_s ? bus.step : step_lat_r;
    last_s     = (cnt_r == step_eff_s);
    accept_s   = bus.in_valid & ~bus.clear;
    if (bus.clear) begin
      cnt_nxt_s = STEP_ZERO;
    end else if (bus.in_valid) begin
      cnt_nxt_s = last_s ? STEP_ZERO : (cnt_r + STEP_ONE);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Per-cell products of the presented beat.
  always_comb begin
    for (int i = 0; i < N_CELL; i++) begin
      prod_s[i] = mul_f(bus.in_data[DATA_W*N_CELL-1-DATA_W*i -: DATA_W],
                        bus.weight [DATA_W*N_CELL-1-DATA_W*i -: DATA_W]);
    end
  end

  // Adder tree, bias/accumulator selection, shift, ReLU and saturation.
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    for (int i = 0; i < N_CELL; i++) begin
      sum_s = sum_s + {{(ACC_W-PROD_W){s1_prod_r[i][PROD_W-1]}}, s1_prod_r[i]};
    end
    if (s1_first_r) begin
      base_s = {{(ACC_W-BIAS_W){s1_bias_r[BIAS_W-1]}}, s1_bias_r};
    end else begin
      base_s = acc_r;
    end
    total_s   = base_s + sum_s;
    shifted_s = total_s >>> s1_shift_r;
    // ReLU is applied to the shifted value, before saturation.
    if (s1_relu_r && shifted_s[ACC_W-1]) begin
      relu_s = {ACC_W{1'b0}};
    end else begin
      relu_s = shifted_s;
    end
    result_s = sat_f(relu_s);
  end

  // Group counter, busy flag and stage-1 capture of an accepted beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r      <= STEP_ZERO;
      step_lat_r <= STEP_ZERO;
      busy_r     <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_bias_r  <= {BIAS_W{1'b0}};
      s1_shift_r <= {SHIFT_W{1'b0}};
      s1_relu_r  <= 1'b0;
      for (int i = 0; i < N_CELL; i++) begin
        s1_prod_r[i] <= {PROD_W{1'b0}};
      end
    end else begin
      cnt_r      <= cnt_nxt_s;
      busy_r     <= (cnt_nxt_s != STEP_ZERO);
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_first_r <= first_s;
        s1_last_r  <= last_s;
        s1_bias_r  <= bus.bias;
        s1_shift_r <= bus.shift;
        s1_relu_r  <= bus.relu_en;
        for (int i = 0; i < N_CELL; i++) begin
          s1_prod_r[i] <= prod_s[i];
        end
        if (first_s) begin
          step_lat_r <= bus.step;
        end
      end
    end
  end

  // Stage 2: accumulate and emit the group result; a clear discards the
  // beat currently in stage 1 and suppresses its pulse, out_data is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r       <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
    end else if (bus.clear) begin
      out_valid_r <= 1'b0;
    end else if (s1_valid_r) begin
      acc_r       <= total_s;
      out_valid_r <= s1_last_r;
      if (s1_last_r) begin
        out_data_r <= result_s;
      end
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_pe_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_acc
// Directed scenarios followed by randomized beats, all checked every cycle
// against a group-level reference model (open group, beats remaining, running
// integer total, pending result).
// ---------------------------------------------------------------------------
module tb_pe_mac_acc;
  localparam int DW = 8;
  localparam int NC = 9;
  localparam int BW = 16;
  localparam int AW = 28;
  localparam int OW = 8;
  localparam int SW = 3;
  localparam int HW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  pe_mac_acc_if #(.DATA_W(DW), .N_CELL(NC), .BIAS_W(BW), .OUT_W(OW),
                  .STEP_W(SW), .SHIFT_W(HW)) bus ();

  pe_mac_acc #(.DATA_W(DW), .N_CELL(NC), .BIAS_W(BW), .ACC_W(AW), .OUT_W(OW),
               .STEP_W(SW), .SHIFT_W(HW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit     m_open;
  int     m_cnt;
  int     m_step;
  longint m_acc;
  bit     m_pend;
  int     m_pend_val;
  bit     m_ov;
  int     m_od;
  bit     m_busy;

  function automatic logic [71:0] fill(input int x);
    logic [71:0] r;
    for (int i = 0; i < NC; i++) r[71-8*i -: 8] = x[7:0];
    return r;
  endfunction

  function automatic logic [71:0] first_only(input int x);
    logic [71:0] r;
    r = '0;
    r[71:64] = x[7:0];
    return r;
  endfunction

  function automatic longint dot(input logic [71:0] d, input logic [71:0] w);
    longint s;
    int a;
    int b;
    s = 0;
    for (int i = 0; i < NC; i++) begin
      a = $signed(d[71-8*i -: 8]);
      b = $signed(w[71-8*i -: 8]);
      s = s + a * b;
    end
    return s;
  endfunction

  // floor(t / 2^sh), optional ReLU, clamp to [-128, 127]
  function automatic int ref_result(input longint t, input int sh, input bit re);
    longint d;
    longint q;
    d = longint'(1) << sh;
    q = t / d;
    if (t < 0 && q * d != t) q = q - 1;
    if (re && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic compare(input string tag);
    logic [7:0] exp_od;
    exp_od = m_od[7:0];
    n_tests++;
    assert (bus.out_valid === m_ov) else begin
      n_fail++;
      $error("FAIL %s out_valid got %b exp %b", tag, bus.out_valid, m_ov);
    end
    n_tests++;
    assert (bus.out_data === exp_od) else begin
      n_fail++;
      $error("FAIL %s out_data got %0d exp %0d", tag, $signed(bus.out_data), $signed(exp_od));
    end
    n_tests++;
    assert (bus.busy === m_busy) else begin
      n_fail++;
      $error("FAIL %s busy got %b exp %b", tag, bus.busy, m_busy);
    end
  endtask

  task automatic chk_const(input string tag, input logic [7:0] exp_od);
    n_tests++;
    assert (bus.out_data === exp_od) else begin
      n_fail++;
      $error("FAIL %s out_data got %0d exp %0d", tag, $signed(bus.out_data), $signed(exp_od));
    end
  endtask

  task automatic cyc(input bit v, input bit clr, input logic [71:0] d, input logic [71:0] w,
                     input logic [15:0] b, input logic [2:0] st, input logic [2:0] sh,
                     input bit re, input string tag);
    bus.in_valid = v;
    bus.clear    = clr;
    bus.in_data  = d;
    bus.weight   = w;
    bus.bias     = b;
    bus.step     = st;
    bus.shift    = sh;
    bus.relu_en  = re;
    reset        = 1'b1;
    @(posedge clk);
    if (clr) begin
      m_ov = 1'b0;
    end else begin
      m_ov = m_pend;
      if (m_pend) m_od = m_pend_val;
    end
    m_pend = 1'b0;
    if (clr) begin
      m_open = 1'b0;
    end else if (v) begin
      if (!m_open) begin
        m_open = 1'b1;
        m_acc  = longint'($signed(b));
        m_step = int'(st);
        m_cnt  = 0;
      end
      m_acc = m_acc + dot(d, w);
      if (m_cnt == m_step) begin
        m_pend     = 1'b1;
        m_pend_val = ref_result(m_acc, int'(sh), re);
        m_open     = 1'b0;
      end else begin
        m_cnt++;
      end
    end
    m_busy = m_open;
    #1;
    compare(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, '0, '0, 16'h0000, 3'd0, 3'd0, 1'b0, tag);
  endtask

  task automatic rst_cyc(input string tag);
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.clear    = 1'b0;
    bus.in_data  = fill(3);
    bus.weight   = fill(3);
    bus.bias     = 16'h0007;
    bus.step     = 3'd0;
    bus.shift    = 3'd0;
    bus.relu_en  = 1'b0;
    @(posedge clk);
    m_open = 1'b0;
    m_cnt  = 0;
    m_acc  = 0;
    m_pend = 1'b0;
    m_ov   = 1'b0;
    m_od   = 0;
    m_busy = 1'b0;
    #1;
    compare(tag);
    reset = 1'b1;
  endtask

  initial begin
    logic [71:0] rd;
    logic [71:0] rw;
    rst_cyc("reset0");
    rst_cyc("reset1");

    // 1: step=0, ones -> 9, busy stays low
    cyc(1'b1, 1'b0, fill(1), fill(1), 16'h0000, 3'd0, 3'd0, 1'b0, "t1_beat");
    idle("t1_w1");
    chk_const("t1_val", 8'd9);
    idle("t1_w2");

    // 2: saturation both ways
    cyc(1'b1, 1'b0, fill(127), fill(127), 16'h0000, 3'd0, 3'd0, 1'b0, "t2_pos");
    cyc(1'b1, 1'b0, fill(-128), fill(127), 16'h0000, 3'd0, 3'd0, 1'b0, "t2_neg");
    chk_const("t2_pos_val", 8'd127);
    idle("t2_w1");
    chk_const("t2_neg_val", 8'h80);
    idle("t2_w2");

    // 3: step=2, bias=5, gap between beats 2 and 3 -> 32
    cyc(1'b1, 1'b0, fill(1), fill(1), 16'd5, 3'd2, 3'd0, 1'b0, "t3_b1");
    cyc(1'b1, 1'b0, fill(1), fill(1), 16'd99, 3'd0, 3'd0, 1'b0, "t3_b2");
    idle("t3_g1");
    idle("t3_g2");
    idle("t3_g3");
    cyc(1'b1, 1'b0, fill(1), fill(1), 16'd0, 3'd0, 3'd0, 1'b0, "t3_b3");
    idle("t3_w1");
    chk_const("t3_val", 8'd32);
    idle("t3_w2");

    // 4: floor shift and ReLU
    cyc(1'b1, 1'b0, first_only(-41), fill(1), 16'h0000, 3'd0, 3'd3, 1'b0, "t4_neg");
    cyc(1'b1, 1'b0, first_only(-41), fill(1), 16'h0000, 3'd0, 3'd3, 1'b1, "t4_relu");
    chk_const("t4_neg_val", 8'hFA);
    cyc(1'b1, 1'b0, first_only(100), fill(1), 16'h0000, 3'd0, 3'd3, 1'b0, "t4_pos");
    chk_const("t4_relu_val", 8'd0);
    idle("t4_w1");
    chk_const("t4_pos_val", 8'd12);
    idle("t4_w2");

    // 5: step=1, continuous, bias=-2 -> 16, 16
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, fill(1), fill(1), 16'hFFFE, 3'd1, 3'd0, 1'b0, "t5_beat");
    end
    idle("t5_w1");
    chk_const("t5_val", 8'd16);
    idle("t5_w2");

    // 6: clear abandons a partial group (beat on the clear cycle dropped)
    cyc(1'b1, 1'b0, fill(1), fill(1), 16'h0000, 3'd2, 3'd0, 1'b0, "t6_b1");
    cyc(1'b1, 1'b1, fill(5), fill(5), 16'h0000, 3'd0, 3'd0, 1'b0, "t6_clr");
    cyc(1'b1, 1'b0, first_only(4), fill(1), 16'h0000, 3'd0, 3'd0, 1'b0, "t6_b2");
    idle("t6_w1");
    chk_const("t6_clr_val", 8'd4);
    idle("t6_w2");
    // same with reset
    cyc(1'b1, 1'b0, fill(1), fill(1), 16'h0000, 3'd2, 3'd0, 1'b0, "t6r_b1");
    rst_cyc("t6r_rst");
    cyc(1'b1, 1'b0, first_only(4), fill(1), 16'h0000, 3'd0, 3'd0, 1'b0, "t6r_b2");
    idle("t6r_w1");
    chk_const("t6r_val", 8'd4);
    idle("t6r_w2");

    // Randomized beats, gaps, clears and mid-group parameter changes
    for (int k = 0; k < 600; k++) begin
      rd = {$urandom, $urandom, $urandom};
      rw = {$urandom, $urandom, $urandom};
      cyc(($urandom % 10) < 7, ($urandom % 32) == 0, rd, rw,
          16'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), "rand");
      if (k == 300) rst_cyc("rand_rst");
    end
    idle("end_w1");
    idle("end_w2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
